// File: rtl/apb2axi_pkg.sv
// Shared constants for the APB-to-AXI bridge datapath.
// The FIFOs take their default geometry from here.
package apb2axi_pkg;

    localparam int unsigned FifoWidth = 32;
    localparam int unsigned FifoDepth = 16;

endpackage

// File: rtl/apb2axi_fifo_sync.sv
// Single-clock FIFO with valid/ready on both sides.
// It has an optional registered head stage and almost-full/almost-empty flags.
module apb2axi_fifo_sync
    import apb2axi_pkg::*;
#(
    parameter int unsigned WIDTH     = FifoWidth,
    parameter int unsigned DEPTH     = FifoDepth,
    parameter int unsigned REG_OUT   = 0,
    parameter int unsigned AFULL_TH  = DEPTH - 2,
    parameter int unsigned AEMPTY_TH = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       wr_vld,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       wr_rdy,
    output logic                       rd_vld,
    output logic [WIDTH-1:0]           rd_data,
    input  logic                       rd_rdy,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       almost_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AEMPTY_TH);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;
    logic             mem_we;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    endfunction

    // Flow control and flags decode only the count register.
    assign wr_rdy       = (count_q < CNT_FULL);
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);
    assign count        = count_q;

    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_vld && rd_rdy;
    assign mem_we = push && !reset && !flush;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    if (REG_OUT == 0) begin : g_fwft

        assign rd_vld  = (count_q != '0);
        assign rd_data = mem[rd_ptr_q];

        always_ff @(posedge clk) begin
            if (reset || flush) begin
                rd_ptr_q <= '0;
            end else if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end

    end else begin : g_reg_out

        logic             out_vld_q;
        logic [WIDTH-1:0] out_data_q;
        logic [CNT_W-1:0] store_cnt;
        logic             load_out;

        // count includes the head register, so storage holds the remainder.
        assign store_cnt = count_q - CNT_W'(out_vld_q);
        assign load_out  = (!out_vld_q || pop) && (store_cnt != '0);

        assign rd_vld  = out_vld_q;
        assign rd_data = out_data_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_ptr_q   <= '0;
                out_vld_q  <= 1'b0;
                out_data_q <= '0;
            end else if (flush) begin
                rd_ptr_q  <= '0;
                out_vld_q <= 1'b0;
            end else if (load_out) begin
                out_data_q <= mem[rd_ptr_q];
                out_vld_q  <= 1'b1;
                rd_ptr_q   <= ptr_inc(rd_ptr_q);
            end else if (pop) begin
                out_vld_q <= 1'b0;
            end
        end

    end

endmodule

// File: doc/apb2axi_fifo_sync.md
APB2AXI_FIFO_SYNC -- requirements
Module: apb2axi_fifo_sync

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width in bits, >=1.
REQ-002 SHALL have parameter DEPTH, default 16: storage entries, any integer >=2 (power of 2 not required).
REQ-003 SHALL have parameter REG_OUT, default 0: 0 = first-word-fall-through head; 1 = registered output stage.
REQ-004 SHALL have parameter AFULL_TH, default DEPTH-2: almost_full threshold, 1..DEPTH.
REQ-005 SHALL have parameter AEMPTY_TH, default 1: almost_empty threshold, 0..DEPTH-1.
REQ-006 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port flush  input  1  synchronous discard of all contents.
REQ-009 SHALL have port wr_vld  input  1  write request.
REQ-010 SHALL have port wr_data  input  WIDTH  write data.
REQ-011 SHALL have port wr_rdy  output  1  space available.
REQ-012 SHALL have port rd_vld  output  1  head entry valid.
REQ-013 SHALL have port rd_data  output  WIDTH  head entry data.
REQ-014 SHALL have port rd_rdy  input  1  consumer accepts head.
REQ-015 SHALL have port count  output  $clog2(DEPTH+1)  entries held, including the output stage when REG_OUT=1.
REQ-016 SHALL have port almost_full  output  1  count >= AFULL_TH.
REQ-017 SHALL have port almost_empty  output  1  count <= AEMPTY_TH.

Function
REQ-018 Push SHALL occur on a cycle with wr_vld && wr_rdy; pop SHALL occur on a cycle with rd_vld && rd_rdy.
REQ-019 wr_rdy SHALL equal (count < DEPTH), derived from the count register with no dependency on rd_rdy.
REQ-020 When full, wr_rdy SHALL stay low even if a pop occurs that cycle; wr_rdy SHALL rise the cycle after the pop.
REQ-021 REG_OUT=0: rd_vld SHALL equal (count != 0), and rd_data SHALL be the oldest entry, stable while rd_vld && !rd_rdy.
REQ-022 REG_OUT=0: a push into an empty FIFO SHALL raise rd_vld on the next cycle (latency 1); there is no same-cycle bypass.
REQ-023 REG_OUT=1: rd_vld and rd_data SHALL be registers; the output stage SHALL load from storage when empty, or when popped and storage is non-empty; write-to-rd_vld latency SHALL be 2 cycles.
REQ-024 REG_OUT=1: the total capacity (storage plus output stage) SHALL be DEPTH entries.
REQ-025 Order SHALL be strict FIFO, with no loss or duplication under any push/pop pattern.
REQ-026 Read and write pointers SHALL wrap from DEPTH-1 to 0, and SHALL be exactly PTR_W = $clog2(DEPTH) bits wide.
REQ-027 count SHALL update +1 on push only, -1 on pop only, and stay unchanged on simultaneous push and pop.
REQ-028 A simultaneous push and pop at count=0 SHALL NOT occur, because rd_vld is low at count=0.
REQ-029 flush SHALL, on the next edge, set pointers and count to 0, drop rd_vld, and discard any push or pop in the same cycle.
REQ-030 flush SHALL take priority over push and pop.
REQ-031 almost_full and almost_empty SHALL be decoded from the count register only, with no combinational path from wr_vld or rd_rdy.
REQ-032 Pushes while full and pops while empty SHALL be impossible by handshake; the storage array SHALL NOT be written when the push condition is false.

Reset
REQ-033 On reset=1 at a clk edge, the following SHALL be cleared: pointers and count to 0, rd_vld=0, rd_data='0 (REG_OUT=1).
REQ-034 One cycle after reset, outputs SHALL be: wr_rdy=1, almost_empty=1, almost_full=0.
REQ-035 Reset SHALL override flush and any in-flight push or pop, including reset asserted mid-burst.
REQ-036 Storage contents SHALL NOT be reset.
REQ-037 No logic SHALL be sensitive to the reset edge.

Structure
REQ-038 Pointer and count widths SHALL be local parameters; no new shared-package types are needed.
REQ-039 Default WIDTH and DEPTH values SHALL come from the existing apb2axi_pkg constants.
REQ-040 Single module, no sub-module; storage SHALL be an inferred array [0:DEPTH-1], and the REG_OUT stage SHALL be a generate branch.
REQ-041 The block SHALL be a drop-in for single-clock paths, with the same wr_*/rd_* handshake naming as the async FIFO.

Verification
REQ-042 Cover fill/drain: DEPTH=5, REG_OUT=0, push 0x1..0x5 with rd_rdy=0 -> count=5, wr_rdy=0, almost_full=1; then drain -> 0x1..0x5 in order, count=0, almost_empty=1.
REQ-043 Cover wrap: DEPTH=5, 13 pushes interleaved with pops (count never exceeds 3) -> output sequence identical to input, pointers wrap 4->0 at least twice.
REQ-044 Cover full with simultaneous pop: at count=DEPTH, wr_vld=1 and rd_rdy=1 for one cycle -> no push, count=DEPTH-1, and wr_rdy=1 the next cycle.
REQ-045 Cover REG_OUT=1 latency: single push of 0xA5 into empty at cycle t -> rd_vld=1 with rd_data=0xA5 at t+2, count=1 at t+1.
REQ-046 Cover flush: count=3 and flush=1 with wr_vld=1 (0x77) in the same cycle -> next cycle count=0, rd_vld=0, and 0x77 never emerges.
REQ-047 Cover reset mid-burst: reset=1 for one cycle during continuous push/pop -> next cycle count=0, rd_vld=0, wr_rdy=1, and subsequent data correct from the first new push.
